// File: rtl/pn_inject_stage.sv
// Input register stage for the permutation network: ages link flits, injects one local
// flit per cycle into the lowest free slot from a small FIFO, and flags injection starvation.
`ifndef WIDTH_INTERNAL_PV
`define WIDTH_INTERNAL_PV 32
`endif

module pn_inject_stage #(
  parameter int WIDTH     = `WIDTH_INTERNAL_PV,
  parameter int VALID_POS = WIDTH-1,
  parameter int TIME_LSB  = 0,
  parameter int TIME_W    = 8,
  parameter int DEPTH     = 4,
  parameter int STARVE_TH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         din0,
  input  logic [WIDTH-1:0]         din1,
  input  logic [WIDTH-1:0]         din2,
  input  logic [WIDTH-1:0]         din3,
  input  logic [WIDTH-1:0]         inj_flit,
  input  logic                     inj_valid,
  output logic                     inj_ready,
  output logic [WIDTH-1:0]         dout0,
  output logic [WIDTH-1:0]         dout1,
  output logic [WIDTH-1:0]         dout2,
  output logic [WIDTH-1:0]         dout3,
  output logic                     starve,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SC_W  = $clog2(STARVE_TH) + 1;

  function automatic logic [WIDTH-1:0] age_flit(input logic [WIDTH-1:0] f);
    logic [TIME_W-1:0] t;
    t = f[TIME_LSB +: TIME_W];
    age_flit = f;
    age_flit[TIME_LSB +: TIME_W] = (t == {TIME_W{1'b1}}) ? t : t + TIME_W'(1);
  endfunction

  function automatic logic [WIDTH-1:0] inject_flit(input logic [WIDTH-1:0] f);
    inject_flit = f;
    inject_flit[TIME_LSB +: TIME_W] = '0;
    inject_flit[VALID_POS] = 1'b1;
  endfunction

  logic [WIDTH-1:0] din_p0 [4];
  logic [WIDTH-1:0] flit_d [4];
  logic [WIDTH-1:0] flit_p1 [4];
  logic [WIDTH-1:0] mem [DEPTH];
  logic [3:0]       free_p0;
  logic [1:0]       inj_slot;
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt, starve_cnt_next;
  logic             fifo_empty, fifo_full, push, pop, blocked;

  assign din_p0[0] = din0;
  assign din_p0[1] = din1;
  assign din_p0[2] = din2;
  assign din_p0[3] = din3;

  always_comb begin
    for (int i = 0; i < 4; i++) free_p0[i] = ~din_p0[i][VALID_POS];
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(DEPTH));
  assign inj_ready  = ~fifo_full;
  assign push       = inj_valid & ~fifo_full;
  // Pop only reads an entry already in the FIFO, so a same-edge push can never bypass.
  assign pop        = ~fifo_empty & (|free_p0);
  assign blocked    = ~fifo_empty & (free_p0 == 4'b0000);

  always_comb begin
    inj_slot = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (free_p0[i]) inj_slot = 2'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      if (!free_p0[i])
        flit_d[i] = age_flit(din_p0[i]);
      else if (pop && inj_slot == 2'(i))
        flit_d[i] = inject_flit(mem[rd_ptr]);
      else
        flit_d[i] = '0;
    end
  end

  always_comb begin
    if (!blocked)
      starve_cnt_next = '0;
    else if (starve_cnt >= SC_W'(STARVE_TH))
      starve_cnt_next = starve_cnt;
    else
      starve_cnt_next = starve_cnt + SC_W'(1);
  end

  // Stage p0 -> p1: registered flits toward the permutation network
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) flit_p1[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) flit_p1[i] <= flit_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= inj_flit;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      starve     <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_next;
      starve     <= (starve_cnt_next >= SC_W'(STARVE_TH));
    end
  end

  assign dout0      = flit_p1[0];
  assign dout1      = flit_p1[1];
  assign dout2      = flit_p1[2];
  assign dout3      = flit_p1[3];
  assign fifo_count = count;

endmodule

// File: tb/tb_pn_inject_stage.sv
// Scoreboard bench for pn_inject_stage: a queue-based reference model predicts each
// registered cycle, expectations are queued before the edge and compared after it.
module tb_pn_inject_stage;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int TH    = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [W-1:0]  din0 = '0, din1 = '0, din2 = '0, din3 = '0;
  logic [W-1:0]  inj_flit = '0;
  logic          inj_valid = 1'b0;
  logic          inj_ready;
  logic [W-1:0]  dout0, dout1, dout2, dout3;
  logic          starve;
  logic [2:0]    fifo_count;

  pn_inject_stage #(
    .WIDTH(W), .VALID_POS(W-1), .TIME_LSB(0), .TIME_W(8), .DEPTH(DEPTH), .STARVE_TH(TH)
  ) dut (
    .clk(clk), .reset(reset),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3),
    .inj_flit(inj_flit), .inj_valid(inj_valid), .inj_ready(inj_ready),
    .dout0(dout0), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .starve(starve), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4*W-1:0] d;
    logic           st;
    logic [2:0]     cnt;
  } exp_t;

  exp_t        sbq [$];
  logic [W-1:0] mq [$];
  int          m_scnt = 0;
  logic        m_starve = 1'b0;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] mkf(input logic v, input logic [22:0] pl, input logic [7:0] age);
    return {v, pl, age};
  endfunction

  function automatic logic [W-1:0] age_up(input logic [W-1:0] f);
    int a;
    a = int'(f[7:0]);
    a = (a < 255) ? a + 1 : 255;
    return {f[W-1:8], a[7:0]};
  endfunction

  task automatic step();
    logic [W-1:0] dn [4];
    logic [W-1:0] ed [4];
    exp_t e, g;
    int   fr;
    bit   inj, blk, full;
    dn[0] = din0; dn[1] = din1; dn[2] = din2; dn[3] = din3;
    full = (mq.size() == DEPTH);
    chk("inj_ready", 64'(inj_ready), 64'(!full));
    fr = -1;
    for (int i = 0; i < 4; i++) begin
      if (dn[i][W-1]) ed[i] = age_up(dn[i]);
      else begin
        ed[i] = '0;
        if (fr < 0) fr = i;
      end
    end
    inj = (mq.size() > 0) && (fr >= 0);
    blk = (mq.size() > 0) && (fr < 0);
    if (inj) begin
      ed[fr] = {1'b1, mq[0][W-2:8], 8'h00};
      void'(mq.pop_front());
    end
    if (inj_valid && !full) mq.push_back(inj_flit);
    if (blk) m_scnt = (m_scnt < TH) ? m_scnt + 1 : TH;
    else     m_scnt = 0;
    m_starve = blk && (m_scnt >= TH);
    e.d   = {ed[3], ed[2], ed[1], ed[0]};
    e.st  = m_starve;
    e.cnt = 3'(mq.size());
    sbq.push_back(e);
    @(posedge clk);
    #1;
    g = sbq.pop_front();
    chk("dout0", 64'(dout0), 64'(g.d[W-1:0]));
    chk("dout1", 64'(dout1), 64'(g.d[2*W-1:W]));
    chk("dout2", 64'(dout2), 64'(g.d[3*W-1:2*W]));
    chk("dout3", 64'(dout3), 64'(g.d[4*W-1:3*W]));
    chk("starve", 64'(starve), 64'(g.st));
    chk("fifo_count", 64'(fifo_count), 64'(g.cnt));
  endtask

  task automatic drive(input logic [3:0] vm, input logic iv);
    logic [W-1:0] d [4];
    for (int i = 0; i < 4; i++) d[i] = mkf(vm[i], 23'($urandom), 8'($urandom));
    din0 = d[0]; din1 = d[1]; din2 = d[2]; din3 = d[3];
    inj_valid = iv;
    inj_flit  = mkf(1'($urandom), 23'($urandom), 8'($urandom));
    step();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_dout0"}, 64'(dout0), 64'h0);
    chk({tag, "_dout1"}, 64'(dout1), 64'h0);
    chk({tag, "_dout2"}, 64'(dout2), 64'h0);
    chk({tag, "_dout3"}, 64'(dout3), 64'h0);
    chk({tag, "_count"}, 64'(fifo_count), 64'h0);
    chk({tag, "_ready"}, 64'(inj_ready), 64'h1);
    chk({tag, "_starve"}, 64'(starve), 64'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1;
    check_reset_state("rst_init");
    #11 reset = 1'b0;

    // Aging, including saturation and zeroing of invalid inputs
    din0 = mkf(1'b1, 23'h12345, 8'd5);
    din1 = mkf(1'b0, 23'h7abcd, 8'd3);
    din2 = mkf(1'b1, 23'h00f0f, 8'd255);
    din3 = mkf(1'b0, 23'h55555, 8'd9);
    inj_valid = 1'b0;
    step();
    chk("age_inc", 64'(dout0[7:0]), 64'd6);
    chk("age_sat", 64'(dout2[7:0]), 64'd255);

    // Lowest free slot: push A, B while blocked, then free slots 2/3
    drive(4'hF, 1'b1);
    drive(4'hF, 1'b1);
    drive(4'b0011, 1'b0);
    drive(4'b0011, 1'b0);

    // Fill to full, attempt a fifth push, drain one per cycle, then wrap
    for (int k = 0; k < 4; k++) drive(4'hF, 1'b1);
    chk("full_ready", 64'(inj_ready), 64'h0);
    drive(4'hF, 1'b1);
    for (int k = 0; k < 4; k++) drive(4'b0111, 1'b0);
    for (int k = 0; k < 6; k++) drive((k % 2 == 0) ? 4'b0111 : 4'hF, 1'b1);
    for (int k = 0; k < 4; k++) drive(4'b0111, 1'b0);

    // Simultaneous push and pop at count 2
    drive(4'hF, 1'b1);
    drive(4'hF, 1'b1);
    drive(4'b0111, 1'b1);
    chk("pushpop_count", 64'(fifo_count), 64'd2);
    drive(4'b0111, 1'b0);
    drive(4'b0111, 1'b0);

    // Starvation: one queued flit, 20 fully-occupied cycles, then one free slot
    drive(4'hF, 1'b1);
    for (int k = 0; k < 20; k++) drive(4'hF, 1'b0);
    chk("starve_high", 64'(starve), 64'h1);
    drive(4'b0111, 1'b0);
    chk("starve_clear", 64'(starve), 64'h0);
    drive(4'hF, 1'b0);

    // Asynchronous reset mid-cycle with three entries queued
    for (int k = 0; k < 3; k++) drive(4'hF, 1'b1);
    chk("pre_reset_count", 64'(fifo_count), 64'd3);
    #2;
    inj_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_reset_state("rst_async");
    mq.delete();
    m_scnt = 0;
    m_starve = 1'b0;
    @(posedge clk);
    #1;
    check_reset_state("rst_held");
    #2 reset = 1'b0;
    drive(4'b0101, 1'b0);
    drive(4'b0000, 1'b0);

    // Random traffic
    for (int k = 0; k < 300; k++) drive(4'($urandom), 1'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
